// File: rtl/wb_gpio_pwm.sv
`default_nettype none
// ============================================================================
// Module      : wb_gpio_pwm
// Description : Wishbone GPIO controller with per-channel static/blink/PWM
//               output modes, output enables, synchronised inputs and
//               rising-edge interrupts.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_gpio_pwm #(
    parameter int NCH     = 7,
    parameter int PWM_W   = 8,
    parameter int PRESC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [NCH-1:0]   pin_in,
    output logic [NCH-1:0]   pin_out,
    output logic [NCH-1:0]   pin_oeb,
    output logic             irq
);

    localparam logic [5:0] c_IDX_OUT   = 6'h00;
    localparam logic [5:0] c_IDX_OEB   = 6'h01;
    localparam logic [5:0] c_IDX_IN    = 6'h02;
    localparam logic [5:0] c_IDX_MODE  = 6'h03;
    localparam logic [5:0] c_IDX_PRESC = 6'h04;
    localparam logic [5:0] c_IDX_MASK  = 6'h05;
    localparam logic [5:0] c_IDX_STAT  = 6'h06;
    localparam int         c_DUTY_BASE = 16;

    logic                   r_ack;
    logic [31:0]            r_dat;
    logic [NCH-1:0]         r_out;
    logic [NCH-1:0]         r_oeb;
    logic [2*NCH-1:0]       r_mode;
    logic [PRESC_W-1:0]     r_presc;
    logic [NCH-1:0]         r_mask;
    logic [NCH-1:0]         r_stat;
    logic [NCH*PWM_W-1:0]   r_duty;
    logic [PRESC_W-1:0]     r_pc;
    logic [PWM_W-1:0]       r_cnt;
    logic                   r_blink_ph;
    logic [NCH-1:0]         r_s1;
    logic [NCH-1:0]         r_s2;
    logic [NCH-1:0]         r_prev;
    logic [NCH-1:0]         r_pin_out;

    logic                   w_req;
    logic                   w_wr;
    logic                   w_rd;
    logic [5:0]             w_idx;
    logic [31:0]            w_wmask;
    logic [31:0]            w_rdata;
    logic                   w_tick;
    logic                   w_wrap;
    logic [NCH-1:0]         w_rise;
    logic [NCH-1:0]         w_clr;
    logic [NCH-1:0]         w_chan;
    logic [NCH-1:0]         w_out_nx;
    logic [NCH-1:0]         w_oeb_nx;
    logic [2*NCH-1:0]       w_mode_nx;
    logic [PRESC_W-1:0]     w_presc_nx;
    logic [NCH-1:0]         w_mask_nx;
    logic                   w_unused;

    // The pending ack blocks a new request, so held strobes ack every other cycle.
    assign w_req   = wbs_stb_i & wbs_cyc_i & ~r_ack;
    assign w_wr    = w_req & wbs_we_i;
    assign w_rd    = w_req & ~wbs_we_i;
    assign w_idx   = wbs_adr_i[7:2];
    assign w_wmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                      {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

    assign w_out_nx   = (r_out   & ~w_wmask[NCH-1:0])     | (wbs_dat_i[NCH-1:0]     & w_wmask[NCH-1:0]);
    assign w_oeb_nx   = (r_oeb   & ~w_wmask[NCH-1:0])     | (wbs_dat_i[NCH-1:0]     & w_wmask[NCH-1:0]);
    assign w_mode_nx  = (r_mode  & ~w_wmask[2*NCH-1:0])   | (wbs_dat_i[2*NCH-1:0]   & w_wmask[2*NCH-1:0]);
    assign w_presc_nx = (r_presc & ~w_wmask[PRESC_W-1:0]) | (wbs_dat_i[PRESC_W-1:0] & w_wmask[PRESC_W-1:0]);
    assign w_mask_nx  = (r_mask  & ~w_wmask[NCH-1:0])     | (wbs_dat_i[NCH-1:0]     & w_wmask[NCH-1:0]);
    assign w_clr      = (w_wr && w_idx == c_IDX_STAT) ? (wbs_dat_i[NCH-1:0] & w_wmask[NCH-1:0]) : '0;

    assign w_tick = (r_pc >= r_presc);
    assign w_wrap = w_tick & (&r_cnt);
    assign w_rise = r_s2 & ~r_prev;

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            c_IDX_OUT:   w_rdata[NCH-1:0]     = r_out;
            c_IDX_OEB:   w_rdata[NCH-1:0]     = r_oeb;
            c_IDX_IN:    w_rdata[NCH-1:0]     = r_s2;
            c_IDX_MODE:  w_rdata[2*NCH-1:0]   = r_mode;
            c_IDX_PRESC: w_rdata[PRESC_W-1:0] = r_presc;
            c_IDX_MASK:  w_rdata[NCH-1:0]     = r_mask;
            c_IDX_STAT:  w_rdata[NCH-1:0]     = r_stat;
            default:     w_rdata              = '0;
        endcase
        for (int ch = 0; ch < NCH; ch++) begin
            if (w_idx == 6'(c_DUTY_BASE + ch)) begin
                w_rdata[PWM_W-1:0] = r_duty[ch*PWM_W +: PWM_W];
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [1:0] w_m;
        assign w_m       = r_mode[2*g +: 2];
        // Mode 2'b11 falls through to static drive.
        assign w_chan[g] = (w_m == 2'b10) ? (r_cnt < r_duty[g*PWM_W +: PWM_W]) :
                           (w_m == 2'b01) ? (r_out[g] & r_blink_ph) :
                                            r_out[g];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_out      <= '0;
            r_oeb      <= '1;
            r_mode     <= '0;
            r_presc    <= '0;
            r_mask     <= '0;
            r_stat     <= '0;
            r_duty     <= '0;
            r_pc       <= '0;
            r_cnt      <= '0;
            r_blink_ph <= 1'b0;
            r_s1       <= '0;
            r_s2       <= '0;
            r_prev     <= '0;
            r_pin_out  <= '0;
        end else begin
            r_ack <= w_req;
            if (w_rd) begin
                r_dat <= w_rdata;
            end
            if (w_wr) begin
                case (w_idx)
                    c_IDX_OUT:   r_out   <= w_out_nx;
                    c_IDX_OEB:   r_oeb   <= w_oeb_nx;
                    c_IDX_MODE:  r_mode  <= w_mode_nx;
                    c_IDX_PRESC: r_presc <= w_presc_nx;
                    c_IDX_MASK:  r_mask  <= w_mask_nx;
                    default:     ;
                endcase
            end
            for (int ch = 0; ch < NCH; ch++) begin
                if (w_wr && w_idx == 6'(c_DUTY_BASE + ch)) begin
                    r_duty[ch*PWM_W +: PWM_W] <=
                        (r_duty[ch*PWM_W +: PWM_W] & ~w_wmask[PWM_W-1:0]) |
                        (wbs_dat_i[PWM_W-1:0] & w_wmask[PWM_W-1:0]);
                end
            end

            r_pc <= w_tick ? '0 : r_pc + 1'b1;
            if (w_tick) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_wrap) begin
                r_blink_ph <= ~r_blink_ph;
            end

            r_s1   <= pin_in;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            // A new edge outranks a simultaneous software clear.
            r_stat <= (r_stat & ~w_clr) | w_rise;

            r_pin_out <= w_chan;
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign pin_out   = r_pin_out;
    assign pin_oeb   = r_oeb;
    assign irq       = |(r_stat & r_mask);

    assign w_unused = ^{wbs_adr_i[31:8], wbs_adr_i[1:0], wbs_dat_i, w_wmask};

endmodule
`default_nettype wire
